// File: rtl/wave_conditioner.sv
// wave_conditioner: synchronise, deglitch, edge-detect and idle-time the raw waves A and B.
// Defining WAVE_COND_PHASE_EN adds an A-rise to B-rise phase counter; otherwise phase outputs are tied to 0.

module wave_conditioner_chan #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned IDLE_CYCLES = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic idle,
  output logic rise_next
);
  localparam logic [7:0]  FILT_MAX = 8'(FILT_LEN);
  localparam logic [31:0] IDLE_MAX = 32'(IDLE_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  logic [7:0]             filt_cnt;
  logic [7:0]             filt_inc;
  logic                   accept;
  logic [31:0]            idle_cnt;
  logic [31:0]            idle_cnt_next;

  assign synced    = sync[SYNC_STAGES-1];
  assign filt_inc  = filt_cnt + 8'd1;
  // accept is the edge on which clean toggles; strobes, idle and phase all key off it.
  assign accept    = (synced != clean) && (filt_inc == FILT_MAX);
  assign rise_next = accept & synced;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    idle_cnt_next = idle_cnt;
    if (accept)
      idle_cnt_next = '0;
    else if (idle_cnt != IDLE_MAX)
      idle_cnt_next = idle_cnt + 32'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= '0;
      filt_cnt <= '0;
      clean    <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      idle_cnt <= '0;
      idle     <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], raw};
      rise     <= accept & synced;
      fall     <= accept & ~synced;
      idle_cnt <= idle_cnt_next;
      idle     <= (idle_cnt_next == IDLE_MAX);
      if (synced == clean) begin
        filt_cnt <= '0;
      end else if (accept) begin
        clean    <= synced;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_inc;
      end
    end
  end
endmodule

module wave_conditioner #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned IDLE_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        A,
  input  logic        B,
  output logic        A_clean,
  output logic        B_clean,
  output logic        A_rise,
  output logic        A_fall,
  output logic        B_rise,
  output logic        B_fall,
  output logic        A_idle,
  output logic        B_idle,
  output logic [31:0] phase_cnt,
  output logic        phase_valid
);
  logic a_rise_next;
  logic b_rise_next;

  wave_conditioner_chan #(
    .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .IDLE_CYCLES(IDLE_CYCLES)
  ) u_chan_a (
    .clk(clk), .rst_n(rst_n), .raw(A), .clean(A_clean), .rise(A_rise),
    .fall(A_fall), .idle(A_idle), .rise_next(a_rise_next)
  );

  wave_conditioner_chan #(
    .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .IDLE_CYCLES(IDLE_CYCLES)
  ) u_chan_b (
    .clk(clk), .rst_n(rst_n), .raw(B), .clean(B_clean), .rise(B_rise),
    .fall(B_fall), .idle(B_idle), .rise_next(b_rise_next)
  );

`ifdef WAVE_COND_PHASE_EN
  typedef enum logic {PH_IDLE, PH_ARMED} phase_state_t;

  phase_state_t state, state_next;
  logic [31:0]  count, count_next, count_inc, phase_cnt_next;
  logic         phase_valid_next;

  // count holds cycles elapsed since the A rise strobe; the B strobe cycle itself is included.
  assign count_inc = (count == '1) ? count : count + 32'd1;

  always_comb begin
    state_next       = state;
    count_next       = count;
    phase_cnt_next   = phase_cnt;
    phase_valid_next = 1'b0;
    if (a_rise_next && b_rise_next) begin
      state_next       = PH_IDLE;
      count_next       = '0;
      phase_cnt_next   = '0;
      phase_valid_next = 1'b1;
    end else if (a_rise_next) begin
      state_next = PH_ARMED;
      count_next = '0;
    end else if (state == PH_ARMED) begin
      if (b_rise_next) begin
        state_next       = PH_IDLE;
        phase_cnt_next   = count_inc;
        phase_valid_next = 1'b1;
      end else begin
        count_next = count_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PH_IDLE;
      count       <= '0;
      phase_cnt   <= '0;
      phase_valid <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      phase_cnt   <= phase_cnt_next;
      phase_valid <= phase_valid_next;
    end
  end
`else
  logic phase_unused;

  assign phase_unused = a_rise_next | b_rise_next;
  assign phase_cnt    = '0;
  assign phase_valid  = 1'b0;
`endif
endmodule

// File: tb/tb_wave_conditioner.sv
// Directed bench for wave_conditioner (SYNC_STAGES=2, FILT_LEN=4, IDLE_CYCLES=100).
// Phase expectations follow WAVE_COND_PHASE_EN as defined for the build.

module tb_wave_conditioner;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        A, B;
  logic        A_clean, B_clean, A_rise, A_fall, B_rise, B_fall, A_idle, B_idle;
  logic [31:0] phase_cnt;
  logic        phase_valid;

  int checks = 0;
  int passed = 0;
  logic phase_seen = 1'b0;
  logic pulse_seen;

`ifdef WAVE_COND_PHASE_EN
  localparam logic [31:0] EXP_PHASE = 32'd25;
  localparam logic        EXP_VALID = 1'b1;
`else
  localparam logic [31:0] EXP_PHASE = 32'd0;
  localparam logic        EXP_VALID = 1'b0;
`endif

  wave_conditioner #(.SYNC_STAGES(2), .FILT_LEN(4), .IDLE_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B),
    .A_clean(A_clean), .B_clean(B_clean), .A_rise(A_rise), .A_fall(A_fall),
    .B_rise(B_rise), .B_fall(B_fall), .A_idle(A_idle), .B_idle(B_idle),
    .phase_cnt(phase_cnt), .phase_valid(phase_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (phase_valid !== 1'b0 || phase_cnt !== 32'd0) phase_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] outs();
    return {A_clean, A_rise, A_fall, A_idle, B_clean, B_rise, B_fall, B_idle};
  endfunction

  initial begin
    // 1: reset state, then A held high -> rise on the 6th edge
    rst_n = 1'b0; A = 1'b0; B = 1'b0;
    tick(3);
    check("reset_outs", 32'(outs()), 32'h0);
    check("reset_phase", phase_cnt, 32'd0);
    check("reset_pvalid", 32'(phase_valid), 32'd0);
    rst_n = 1'b1; A = 1'b1;
    tick(5);
    check("s1_edge5_clean", 32'(A_clean), 32'd0);
    check("s1_edge5_rise", 32'(A_rise), 32'd0);
    tick(1);
    check("s1_edge6", 32'(outs()), 32'b1100_0000);
    tick(1);
    check("s1_edge7", 32'(outs()), 32'b1000_0000);

    // 2: fall, then a 3-cycle glitch (rejected) and a 4-cycle pulse (accepted)
    A = 1'b0;
    tick(6);
    check("s2_fall", 32'({A_clean, A_rise, A_fall}), 32'b001);
    tick(2);
    A = 1'b1;
    tick(3);
    A = 1'b0;
    pulse_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (A_clean || A_rise || A_fall) pulse_seen = 1'b1;
    end
    check("s2_glitch3", 32'(pulse_seen), 32'd0);
    A = 1'b1;
    tick(4);
    A = 1'b0;
    tick(1);
    check("s2_p4_edge5", 32'({A_clean, A_rise}), 32'b00);
    tick(1);
    check("s2_p4_rise", 32'({A_clean, A_rise, A_fall}), 32'b110);
    tick(3);
    check("s2_p4_edge9", 32'({A_clean, A_rise, A_fall}), 32'b100);
    tick(1);
    check("s2_p4_fall", 32'({A_clean, A_rise, A_fall}), 32'b001);

    // 3: idle timing from reset and after a qualified B edge
    rst_n = 1'b0; A = 1'b0; B = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(99);
    check("s3_idle_99", 32'({A_idle, B_idle}), 32'b00);
    tick(1);
    check("s3_idle_100", 32'({A_idle, B_idle}), 32'b11);
    B = 1'b1;
    tick(5);
    check("s3_b_pre", 32'({B_clean, B_rise, B_idle}), 32'b001);
    tick(1);
    check("s3_b_rise", 32'({B_clean, B_rise, B_idle}), 32'b110);
    tick(99);
    check("s3_reidle_99", 32'({A_idle, B_idle}), 32'b10);
    tick(1);
    check("s3_reidle_100", 32'({A_idle, B_idle}), 32'b11);

    // 4: reset while A filter count is at 3
    A = 1'b1;
    tick(5);
    check("s4_pre_reset", 32'(outs()), 32'b0001_1001);
    rst_n = 1'b0;
    #1;
    check("s4_async_clear", 32'(outs()), 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check("s4_rel_edge1", 32'(outs()), 32'h0);
    tick(4);
    check("s4_rel_edge5", 32'({A_clean, A_rise, B_rise}), 32'b000);
    tick(1);
    check("s4_rel_edge6", 32'({A_clean, A_rise, B_rise}), 32'b111);

    // 5/6: phase from A rise to B rise 25 cycles later, then coincident rises
    rst_n = 1'b0; A = 1'b0; B = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    A = 1'b1;
    tick(6);
    check("s5_a_rise", 32'(A_rise), 32'd1);
    tick(19);
    B = 1'b1;
    tick(5);
    check("s5_pre_b", 32'({B_rise, phase_valid}), 32'b00);
    tick(1);
    check("s5_b_rise", 32'(B_rise), 32'd1);
    check("s5_pvalid", 32'(phase_valid), 32'(EXP_VALID));
    check("s5_pcnt", phase_cnt, EXP_PHASE);
    tick(1);
    check("s5_pvalid_drop", 32'(phase_valid), 32'd0);
    check("s5_pcnt_hold", phase_cnt, EXP_PHASE);
    A = 1'b0; B = 1'b0;
    tick(8);
    A = 1'b1; B = 1'b1;
    tick(6);
    check("s5_coinc_rises", 32'({A_rise, B_rise}), 32'b11);
    check("s5_coinc_pvalid", 32'(phase_valid), 32'(EXP_VALID));
    check("s5_coinc_pcnt", phase_cnt, 32'd0);
    B = 1'b0;
    tick(8);
    B = 1'b1;
    tick(6);
    check("s5_lone_b_rise", 32'(B_rise), 32'd1);
    check("s5_lone_b_pvalid", 32'(phase_valid), 32'd0);
`ifndef WAVE_COND_PHASE_EN
    check("s6_phase_quiet", 32'(phase_seen), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
